// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FP32 adder front end.
//   fp32_t      : packed IEEE-754 single field layout
//   EXP_MAX/EXP_ZERO/QNAN : special encodings
//   state_t     : operand-stage FSM states
//   fp_classify : returns {is_zero, is_denorm, is_inf, is_nan}
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [7:0]  EXP_ZERO = 8'h00;
  localparam logic [31:0] QNAN     = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_COMPARE,
    S_ISSUE,
    S_WAIT,
    S_BYPASS,
    S_DONE
  } state_t;

  function automatic logic [3:0] fp_classify(input fp32_t f);
    logic exp_zero;
    logic exp_max;
    logic frac_nz;
    exp_zero = (f.exp == EXP_ZERO);
    exp_max  = (f.exp == EXP_MAX);
    frac_nz  = |f.frac;
    return {exp_zero & ~frac_nz, exp_zero & frac_nz, exp_max & ~frac_nz, exp_max & frac_nz};
  endfunction

endpackage

// File: rtl/fpu_add_operand_stage_if.sv
// Bundle of request, adder-issue and result signals for fpu_add_operand_stage.
//   slave  : view of the operand stage itself
//   master : view of the surrounding logic (requester + adder)
interface fpu_add_operand_stage_if;
  logic        start_i;
  logic        op_i;
  logic [6:0]  rounding_mode_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        data_ready_o;
  logic [6:0]  rounding_mode_o;
  logic        x_sign_o;
  logic        y_sign_o;
  logic [7:0]  x_exp_o;
  logic [7:0]  y_exp_o;
  logic [22:0] x_frac_o;
  logic [22:0] y_frac_o;
  logic        x_greater_o;
  logic [7:0]  exp_shift_o;
  logic        x_infinity_o;
  logic        y_infinity_o;
  logic        x_nan_o;
  logic        y_nan_o;
  logic        adder_valid_i;
  logic [31:0] adder_z_i;
  logic        adder_invalid_i;
  logic        adder_overflow_i;
  logic        result_valid_o;
  logic [31:0] z_o;
  logic        except_invalid_operation_o;
  logic        except_overflow_o;

  modport slave (
    input  start_i, op_i, rounding_mode_i, a_i, b_i,
           adder_valid_i, adder_z_i, adder_invalid_i, adder_overflow_i,
    output busy_o, data_ready_o, rounding_mode_o,
           x_sign_o, y_sign_o, x_exp_o, y_exp_o, x_frac_o, y_frac_o,
           x_greater_o, exp_shift_o,
           x_infinity_o, y_infinity_o, x_nan_o, y_nan_o,
           result_valid_o, z_o, except_invalid_operation_o, except_overflow_o
  );

  modport master (
    output start_i, op_i, rounding_mode_i, a_i, b_i,
           adder_valid_i, adder_z_i, adder_invalid_i, adder_overflow_i,
    input  busy_o, data_ready_o, rounding_mode_o,
           x_sign_o, y_sign_o, x_exp_o, y_exp_o, x_frac_o, y_frac_o,
           x_greater_o, exp_shift_o,
           x_infinity_o, y_infinity_o, x_nan_o, y_nan_o,
           result_valid_o, z_o, except_invalid_operation_o, except_overflow_o
  );
endinterface

// File: rtl/fpu_classify.sv
// Combinational field split and classification of one packed FP32 operand.
//   op_i          : packed operand
//   invert_sign_i : flip the sign (effective subtraction on the y side)
//   fields_o      : sign/exp/frac, denormals flushed to signed zero
//   zero_o        : operand is zero after flushing
//   inf_o / nan_o : class flags
module fpu_classify
  import fpu_pkg::*;
(
  input  logic [31:0] op_i,
  input  logic        invert_sign_i,
  output fp32_t       fields_o,
  output logic        zero_o,
  output logic        inf_o,
  output logic        nan_o
);

  fp32_t      raw;
  logic [3:0] cls;

  always_comb begin
    raw           = fp32_t'(op_i);
    cls           = fp_classify(raw);
    fields_o      = raw;
    fields_o.sign = raw.sign ^ invert_sign_i;
    if (cls[2]) fields_o.frac = '0;
    zero_o        = cls[3] | cls[2];
    inf_o         = cls[1];
    nan_o         = cls[0];
  end

endmodule

// File: rtl/fpu_add_operand_stage.sv
// Operand stage in front of the FP32 adder: latches a request, classifies
// both operands, computes magnitude order and alignment shift, then either
// issues one adder transaction (data_ready_o pulse) or resolves zero/denormal
// operands locally. The final result appears on z_o with a result_valid_o pulse.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : request inputs, adder operand outputs, adder response
//                  inputs and registered result outputs
module fpu_add_operand_stage
  import fpu_pkg::*;
#(
  parameter int unsigned MAX_SHIFT = 26
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  fpu_add_operand_stage_if.slave       bus
);

  localparam logic [7:0] SHIFT_SAT = 8'(MAX_SHIFT);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        op_q, op_d;
  logic [6:0]  rm_q, rm_d;
  fp32_t       x_q, x_d, y_q, y_d;
  logic        x_zero_q, x_zero_d, y_zero_q, y_zero_d;
  logic        x_inf_q, x_inf_d, y_inf_q, y_inf_d;
  logic        x_nan_q, x_nan_d, y_nan_q, y_nan_d;
  logic        x_greater_q, x_greater_d;
  logic [7:0]  exp_shift_q, exp_shift_d;
  logic        data_ready_q, data_ready_d;
  logic        result_valid_q, result_valid_d;
  logic [31:0] z_q, z_d;
  logic        inv_q, inv_d, ovf_q, ovf_d;

  fp32_t x_fields, y_fields;
  logic  x_zero_c, x_inf_c, x_nan_c;
  logic  y_zero_c, y_inf_c, y_nan_c;

  fpu_classify u_classify_x (
    .op_i          (a_q),
    .invert_sign_i (1'b0),
    .fields_o      (x_fields),
    .zero_o        (x_zero_c),
    .inf_o         (x_inf_c),
    .nan_o         (x_nan_c)
  );

  fpu_classify u_classify_y (
    .op_i          (b_q),
    .invert_sign_i (op_q),
    .fields_o      (y_fields),
    .zero_o        (y_zero_c),
    .inf_o         (y_inf_c),
    .nan_o         (y_nan_c)
  );

  logic       x_ge_y;
  logic [7:0] exp_diff;
  logic       any_special;

  always_comb begin
    x_ge_y      = {x_q.exp, x_q.frac} >= {y_q.exp, y_q.frac};
    exp_diff    = x_ge_y ? (x_q.exp - y_q.exp) : (y_q.exp - x_q.exp);
    any_special = x_inf_q | y_inf_q | x_nan_q | y_nan_q;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rm_d        = rm_q;
    x_d         = x_q;
    y_d         = y_q;
    x_zero_d    = x_zero_q;
    y_zero_d    = y_zero_q;
    x_inf_d     = x_inf_q;
    y_inf_d     = y_inf_q;
    x_nan_d     = x_nan_q;
    y_nan_d     = y_nan_q;
    x_greater_d = x_greater_q;
    exp_shift_d = exp_shift_q;
    z_d         = z_q;
    inv_d       = inv_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          op_d    = bus.op_i;
          rm_d    = bus.rounding_mode_i;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        x_d      = x_fields;
        y_d      = y_fields;
        x_zero_d = x_zero_c;
        y_zero_d = y_zero_c;
        x_inf_d  = x_inf_c;
        y_inf_d  = y_inf_c;
        x_nan_d  = x_nan_c;
        y_nan_d  = y_nan_c;
        state_d  = S_COMPARE;
      end
      S_COMPARE: begin
        x_greater_d = x_ge_y;
        exp_shift_d = (exp_diff > SHIFT_SAT) ? SHIFT_SAT : exp_diff;
        // Inf/NaN always go to the adder, even when the other side is zero.
        if (!any_special && (x_q.exp == EXP_ZERO || y_q.exp == EXP_ZERO))
          state_d = S_BYPASS;
        else
          state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.adder_valid_i) begin
          z_d     = bus.adder_z_i;
          inv_d   = bus.adder_invalid_i;
          ovf_d   = bus.adder_overflow_i;
          state_d = S_DONE;
        end
      end
      S_BYPASS: begin
        if (x_zero_q && y_zero_q)
          z_d = {x_q.sign & y_q.sign, 31'b0};
        else if (x_zero_q)
          z_d = y_q;
        else
          z_d = x_q;
        inv_d   = 1'b0;
        ovf_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    data_ready_d   = (state_d == S_ISSUE);
    result_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= 1'b0;
      rm_q           <= '0;
      x_q            <= '0;
      y_q            <= '0;
      x_zero_q       <= 1'b0;
      y_zero_q       <= 1'b0;
      x_inf_q        <= 1'b0;
      y_inf_q        <= 1'b0;
      x_nan_q        <= 1'b0;
      y_nan_q        <= 1'b0;
      x_greater_q    <= 1'b0;
      exp_shift_q    <= '0;
      data_ready_q   <= 1'b0;
      result_valid_q <= 1'b0;
      z_q            <= '0;
      inv_q          <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      rm_q           <= rm_d;
      x_q            <= x_d;
      y_q            <= y_d;
      x_zero_q       <= x_zero_d;
      y_zero_q       <= y_zero_d;
      x_inf_q        <= x_inf_d;
      y_inf_q        <= y_inf_d;
      x_nan_q        <= x_nan_d;
      y_nan_q        <= y_nan_d;
      x_greater_q    <= x_greater_d;
      exp_shift_q    <= exp_shift_d;
      data_ready_q   <= data_ready_d;
      result_valid_q <= result_valid_d;
      z_q            <= z_d;
      inv_q          <= inv_d;
      ovf_q          <= ovf_d;
    end
  end

  assign bus.busy_o                     = (state_q != S_IDLE);
  assign bus.data_ready_o               = data_ready_q;
  assign bus.rounding_mode_o            = rm_q;
  assign bus.x_sign_o                   = x_q.sign;
  assign bus.y_sign_o                   = y_q.sign;
  assign bus.x_exp_o                    = x_q.exp;
  assign bus.y_exp_o                    = y_q.exp;
  assign bus.x_frac_o                   = x_q.frac;
  assign bus.y_frac_o                   = y_q.frac;
  assign bus.x_greater_o                = x_greater_q;
  assign bus.exp_shift_o                = exp_shift_q;
  assign bus.x_infinity_o               = x_inf_q;
  assign bus.y_infinity_o               = y_inf_q;
  assign bus.x_nan_o                    = x_nan_q;
  assign bus.y_nan_o                    = y_nan_q;
  assign bus.result_valid_o             = result_valid_q;
  assign bus.z_o                        = z_q;
  assign bus.except_invalid_operation_o = inv_q;
  assign bus.except_overflow_o          = ovf_q;

endmodule

// File: tb/tb_fpu_add_operand_stage.sv
// Directed bench for fpu_add_operand_stage with a result scoreboard.
module tb_fpu_add_operand_stage;
  import fpu_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  fpu_add_operand_stage_if bus ();

  fpu_add_operand_stage #(.MAX_SHIFT(26)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int unsigned errors   = 0;
  int unsigned checks   = 0;
  int unsigned dr_count = 0;
  logic [33:0] sb_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({bus.busy_o, bus.data_ready_o, bus.rounding_mode_o,
                 bus.x_sign_o, bus.y_sign_o, bus.x_exp_o, bus.y_exp_o,
                 bus.x_frac_o, bus.y_frac_o, bus.x_greater_o, bus.exp_shift_o,
                 bus.x_infinity_o, bus.y_infinity_o, bus.x_nan_o, bus.y_nan_o,
                 bus.result_valid_o, bus.z_o,
                 bus.except_invalid_operation_o, bus.except_overflow_o});
  endfunction

  // Scoreboard consumer and issue-pulse counter.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus.data_ready_o) dr_count++;
      if (bus.result_valid_o) begin
        checks++;
        assert (sb_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_result: observed=%0h expected=no result", bus.z_o);
        end
        if (sb_q.size() != 0)
          chk("result", 128'({bus.z_o, bus.except_invalid_operation_o, bus.except_overflow_o}),
              128'(sb_q.pop_front()));
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [6:0] rm);
    @(negedge clk_i);
    bus.a_i = a; bus.b_i = b; bus.op_i = op; bus.rounding_mode_i = rm;
    bus.start_i = 1'b1;
    @(posedge clk_i);
    #1 bus.start_i = 1'b0;
  endtask

  // Full adder-path transaction: issue at the third negedge after start,
  // adder answers one cycle later, result at the fifth negedge.
  task automatic adder_txn(input logic [31:0] a, input logic [31:0] b, input logic op,
                           input logic [6:0] rm, input logic [31:0] az,
                           input logic ai, input logic ao);
    int unsigned dr0;
    dr0 = dr_count;
    sb_q.push_back({az, ai, ao});
    start_op(a, b, op, rm);
    step(3);
    chk("data_ready_at_issue", 128'(bus.data_ready_o), 128'(1));
    step(1);
    bus.adder_valid_i = 1'b1; bus.adder_z_i = az;
    bus.adder_invalid_i = ai; bus.adder_overflow_i = ao;
    step(1);
    bus.adder_valid_i = 1'b0;
    chk("result_valid_adder", 128'(bus.result_valid_o), 128'(1));
    chk("issue_count", 128'(dr_count - dr0), 128'(1));
  endtask

  task automatic bypass_txn(input logic [31:0] a, input logic [31:0] b, input logic op,
                            input logic [31:0] ez);
    int unsigned dr0;
    dr0 = dr_count;
    sb_q.push_back({ez, 1'b0, 1'b0});
    start_op(a, b, op, 7'h00);
    step(4);
    chk("result_valid_bypass", 128'(bus.result_valid_o), 128'(1));
    chk("bypass_no_issue", 128'(dr_count - dr0), 128'(0));
  endtask

  initial begin
    int unsigned dr0;
    bus.start_i = 1'b0; bus.op_i = 1'b0; bus.rounding_mode_i = '0;
    bus.a_i = '0; bus.b_i = '0;
    bus.adder_valid_i = 1'b0; bus.adder_z_i = '0;
    bus.adder_invalid_i = 1'b0; bus.adder_overflow_i = 1'b0;

    step(2);
    chk("reset_outputs", all_outs(), 128'(0));
    rst_i = 1'b0;
    step(1);

    // 1.0 + 2.0
    adder_txn(32'h3F800000, 32'h40000000, 1'b0, 7'h05, 32'h40400000, 1'b0, 1'b0);
    chk("t1_x_greater", 128'(bus.x_greater_o), 128'(0));
    chk("t1_exp_shift", 128'(bus.exp_shift_o), 128'(1));
    chk("t1_x_exp", 128'(bus.x_exp_o), 128'(8'h7F));
    chk("t1_y_exp", 128'(bus.y_exp_o), 128'(8'h80));
    chk("t1_y_frac", 128'(bus.y_frac_o), 128'(0));
    chk("t1_rounding_mode", 128'(bus.rounding_mode_o), 128'(7'h05));

    // 5.0 - 1.0
    adder_txn(32'h40A00000, 32'h3F800000, 1'b1, 7'h01, 32'h40800000, 1'b0, 1'b0);
    chk("t2_y_sign", 128'(bus.y_sign_o), 128'(1));
    chk("t2_x_greater", 128'(bus.x_greater_o), 128'(1));
    chk("t2_exp_shift", 128'(bus.exp_shift_o), 128'(2));
    chk("t2_x_frac", 128'(bus.x_frac_o), 128'(23'h200000));

    // Zero bypass cases
    bypass_txn(32'h00000000, 32'h40400000, 1'b1, 32'hC0400000);
    bypass_txn(32'h80000000, 32'h00000000, 1'b1, 32'h80000000);
    // Denormal flushed to zero, other operand returned
    bypass_txn(32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000);
    chk("denorm_y_frac_flushed", 128'(bus.y_frac_o), 128'(0));

    // Shift clamp, overflow flag passthrough
    adder_txn(32'h7F000000, 32'h3F800000, 1'b0, 7'h00, 32'h7F800000, 1'b0, 1'b1);
    chk("clamp_exp_shift", 128'(bus.exp_shift_o), 128'(26));
    chk("clamp_x_greater", 128'(bus.x_greater_o), 128'(1));

    // Inf + NaN
    adder_txn(32'h7F800000, 32'h7FC00000, 1'b0, 7'h00, QNAN, 1'b1, 1'b0);
    chk("spec_flags", 128'({bus.x_infinity_o, bus.y_infinity_o, bus.x_nan_o, bus.y_nan_o}),
        128'(4'b1001));
    step(1);
    chk("result_pulse_one_cycle", 128'(bus.result_valid_o), 128'(0));
    chk("z_hold", 128'({bus.z_o, bus.except_invalid_operation_o}), 128'({QNAN, 1'b1}));

    // Zero paired with infinity still goes to the adder
    adder_txn(32'h00000000, 32'hFF800000, 1'b0, 7'h00, 32'hFF800000, 1'b0, 1'b0);
    chk("zero_inf_y_inf", 128'(bus.y_infinity_o), 128'(1));

    // a - a: tie gives x_greater=1, no cancellation special case
    adder_txn(32'h40400000, 32'h40400000, 1'b1, 7'h00, 32'h00000000, 1'b0, 1'b0);
    chk("tie_x_greater", 128'(bus.x_greater_o), 128'(1));
    chk("tie_exp_shift", 128'(bus.exp_shift_o), 128'(0));

    // start_i while busy is ignored
    dr0 = dr_count;
    sb_q.push_back({32'h40400000, 1'b0, 1'b0});
    start_op(32'h3F800000, 32'h40000000, 1'b0, 7'h00);
    step(4);
    bus.a_i = 32'h7F800000; bus.start_i = 1'b1;
    step(1);
    bus.start_i = 1'b0;
    step(2);
    chk("busy_in_wait", 128'(bus.busy_o), 128'(1));
    chk("no_relatch_in_wait", 128'(bus.x_exp_o), 128'(8'h7F));
    bus.adder_valid_i = 1'b1; bus.adder_z_i = 32'h40400000;
    bus.adder_invalid_i = 1'b0; bus.adder_overflow_i = 1'b0;
    step(1);
    bus.adder_valid_i = 1'b0;
    chk("busy_start_result_valid", 128'(bus.result_valid_o), 128'(1));
    step(3);
    chk("busy_start_not_queued", 128'({bus.busy_o, 32'(dr_count - dr0)}), 128'({1'b0, 32'd1}));

    // Asynchronous reset in WAIT
    start_op(32'h40400000, 32'h3F800000, 1'b0, 7'h11);
    step(4);
    chk("pre_reset_busy", 128'(bus.busy_o), 128'(1));
    #3 rst_i = 1'b1;
    #1 chk("async_reset_outputs", all_outs(), 128'(0));
    step(1);
    rst_i = 1'b0;

    // Stale adder_valid_i in IDLE
    bus.adder_valid_i = 1'b1; bus.adder_z_i = 32'h12345678;
    step(1);
    chk("stale_valid_no_result", 128'({bus.result_valid_o, bus.busy_o}), 128'(0));
    step(1);
    bus.adder_valid_i = 1'b0;
    chk("stale_valid_z", 128'(bus.z_o), 128'(0));
    step(2);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=not finished expected=finished");
    $fatal(1, "timeout");
  end

endmodule
